// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_arb_pkg
//  Description : Shared types and constants for the two-client register-file
//                arbiter: FSM state encoding, client indices, default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 3;

    localparam logic CLI0 = 1'b0;
    localparam logic CLI1 = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_arbiter_if
//  Description : Bundles both client handshakes and the register-file port
//                of the arbiter. master = client/regfile side, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_arbiter_if #(
    parameter int DATA_W = rf_arb_pkg::DEF_DATA_W,
    parameter int ADDR_W = rf_arb_pkg::DEF_ADDR_W
);
    // client 0
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;
    // client 1
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;
    // register file port
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wAddr;
    logic [DATA_W-1:0] rf_wData;
    logic [ADDR_W-1:0] rf_rAddr;
    logic [DATA_W-1:0] rf_rData;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output rf_rData,
        input  ack0, rdata0, ack1, rdata1,
        input  rf_we, rf_wAddr, rf_wData, rf_rAddr
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  rf_rData,
        output ack0, rdata0, ack1, rdata1,
        output rf_we, rf_wAddr, rf_wData, rf_rAddr
    );

endinterface
`default_nettype wire

// File: rtl/rf_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rf_rr_picker
//  Description : Combinational two-way round-robin pick. A lone eligible
//                client wins; on a tie the client not granted last wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_rr_picker
    import rf_arb_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_gnt,
    output logic       valid,
    output logic       winner
);

    // Select the winner from the eligible set and the previous grant
    always_comb begin
        valid  = |eligible;
        winner = CLI0;
        case (eligible)
            2'b01:   winner = CLI0;
            2'b10:   winner = CLI1;
            2'b11:   winner = ~last_gnt;
            default: winner = CLI0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rf_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_arbiter
//  Description : Two-client round-robin arbiter in front of a single-write,
//                combinational-read register file. One transaction per two
//                cycles: grant edge, one ACCESS cycle, ack pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    rf_arbiter_if.slave   bus
);

    state_t            r_state;
    logic              r_last_gnt;
    logic              r_gnt;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    // The rf drive registers double as the latched command of the winner:
    // they load on the grant edge and hold afterwards, so nothing on the rf
    // port moves outside an access.
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic [1:0]        w_eligible;
    logic              w_valid;
    logic              w_winner;

    // A client acked this cycle is masked so its still-held req is not re-granted
    assign w_eligible = {bus.req1 & ~r_ack1, bus.req0 & ~r_ack0};

    rf_rr_picker u_picker (
        .eligible (w_eligible),
        .last_gnt (r_last_gnt),
        .valid    (w_valid),
        .winner   (w_winner)
    );

    // Arbitration FSM with registered handshake and rf outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= CLI1;
            r_gnt      <= CLI0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt      <= w_winner;
                        r_last_gnt <= w_winner;
                        r_rf_we    <= (w_winner == CLI1) ? bus.we1    : bus.we0;
                        r_rf_addr  <= (w_winner == CLI1) ? bus.addr1  : bus.addr0;
                        r_rf_wdata <= (w_winner == CLI1) ? bus.wdata1 : bus.wdata0;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Write commits in the register file at this same edge
                    r_rf_we <= 1'b0;
                    if (!r_rf_we) begin
                        if (r_gnt == CLI1) r_rdata1 <= bus.rf_rData;
                        else               r_rdata0 <= bus.rf_rData;
                    end
                    if (r_gnt == CLI1) r_ack1 <= 1'b1;
                    else               r_ack0 <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Reset arriving during an access must kill the write in that same cycle
    assign bus.rf_we    = r_rf_we & ~reset;
    assign bus.rf_wAddr = r_rf_addr;
    assign bus.rf_rAddr = r_rf_addr;
    assign bus.rf_wData = r_rf_wdata;
    assign bus.ack0     = r_ack0;
    assign bus.ack1     = r_ack1;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;

endmodule
`default_nettype wire
